// File: rtl/mp_addsub_pkg.sv
// Shared types and default geometry for the multi-precision add/sub sequencer.
package mp_addsub_pkg;
  localparam int W_DEF = 4;
  localparam int N_DEF = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/mp_addsub_seq_if.sv
// Operand/result handshake bundle. Optional z flag when MP_ADDSUB_ZFLAG_EN is defined.
interface mp_addsub_seq_if #(parameter int W = 4, parameter int N = 4);
  logic             in_valid;
  logic             in_ready;
  logic [W*N-1:0]   a;
  logic [W*N-1:0]   b;
  logic             m;
  logic             out_valid;
  logic             out_ready;
  logic [W*N-1:0]   s;
  logic             c;
  logic             v;
  logic             busy;
`ifdef MP_ADDSUB_ZFLAG_EN
  logic             z;

  modport master (output in_valid, a, b, m, out_ready,
                  input  in_ready, out_valid, s, c, v, busy, z);
  modport slave  (input  in_valid, a, b, m, out_ready,
                  output in_ready, out_valid, s, c, v, busy, z);
`else
  modport master (output in_valid, a, b, m, out_ready,
                  input  in_ready, out_valid, s, c, v, busy);
  modport slave  (input  in_valid, a, b, m, out_ready,
                  output in_ready, out_valid, s, c, v, busy);
`endif
endinterface

// File: rtl/mp_addsub_seq_slice.sv
// W-bit carry-lookahead add/sub slice; carry-in comes from the sequencer, not from m.
module addsub_slice #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic [W-1:0] bx, g, p;
  logic [W:0]   cy;
  logic         acc, pp;

  assign bx = b ^ {W{m}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Each carry is a flat sum of generate terms masked by the propagate chain above them.
  always_comb begin
    cy    = '0;
    acc   = 1'b0;
    pp    = 1'b0;
    cy[0] = cin;
    for (int i = 0; i < W; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      cy[i+1] = acc | (pp & cin);
    end
  end

  assign sum  = p ^ cy[W-1:0];
  assign cout = cy[W];
  assign cmsb = cy[W-1];
endmodule

// File: rtl/mp_addsub_seq.sv
// Sequencer: one W-bit slice iterated N times over W*N-bit operands.
// Optional zero flag output when MP_ADDSUB_ZFLAG_EN is defined.
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input logic              clk,
  input logic              rst_n,
  mp_addsub_seq_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e           state, state_n;
  logic [W*N-1:0]   a_q, b_q, s_q;
  logic             m_q, cr, c_q, v_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [IW-1:0]    idx;
  logic             accept, last;
  logic [W-1:0]     sl_a, sl_b, sl_sum;
  logic             sl_cout, sl_cmsb;

  assign sl_a = a_q[int'(idx)*W +: W];
  assign sl_b = b_q[int'(idx)*W +: W];

  addsub_slice #(.W(W)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .m    (m_q),
    .cin  (cr),
    .sum  (sl_sum),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_n = RUN;
      end
      RUN: if (idx == IW'(N - 1)) begin
        last    = 1'b1;
        state_n = DONE;
      end
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  // Handshake outputs are flopped from the next state so every port is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= 1'b0;
      s_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      cr          <= 1'b0;
      idx         <= '0;
    end else begin
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
      busy_q      <= (state_n != IDLE);
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        m_q <= bus.m;
        cr  <= bus.m;
        idx <= '0;
      end
      if (state == RUN) begin
        s_q[int'(idx)*W +: W] <= sl_sum;
        cr                    <= sl_cout;
        idx                   <= idx + 1'b1;
        if (last) begin
          c_q <= sl_cout;
          v_q <= sl_cout ^ sl_cmsb;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;

`ifdef MP_ADDSUB_ZFLAG_EN
  logic z_acc, z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_acc <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      if (accept) z_acc <= 1'b1;
      if (state == RUN) begin
        z_acc <= z_acc & ~|sl_sum;
        if (last) z_q <= z_acc & ~|sl_sum;
      end
    end
  end

  assign bus.z = z_q;
`endif
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed + randomized bench for mp_addsub_seq at W=4, N=4.
module tb_mp_addsub_seq;
  logic clk, rst_n;
  int   checks = 0;
  int   errors = 0;

  mp_addsub_seq_if #(.W(4), .N(4)) bus ();

  mp_addsub_seq #(.W(4), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width add of A and (B or ~B) plus m; overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv, input logic mv);
    logic [16:0] r;
    logic        ov;
    r = {1'b0, av} + {1'b0, (mv ? ~bv : bv)} + {16'd0, mv};
    if (mv) ov = (av[15] != bv[15]) && (r[15] != av[15]);
    else    ov = (av[15] == bv[15]) && (r[15] != av[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic mv,
                        input int hold, output int lat);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.m = mv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~av;
    bus.b = ~bv;
    bus.m = ~mv;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("out_valid_wait", bus.out_valid, 1);
    repeat (hold) begin @(posedge clk); #1; end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_clr", bus.out_valid, 0);
  endtask

  initial begin
    int lat;
    logic [15:0] av, bv, s_hold;
    logic        mv;
    logic [17:0] exp;

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.m = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_v", bus.v, 0);
`ifdef MP_ADDSUB_ZFLAG_EN
    chk("rst_z", bus.z, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with latency check
    run_op(16'h1234, 16'h0FFF, 1'b0, 0, lat);
    chk("t1_lat", lat, 4);
    chk("t1_s", bus.s, 16'h2233);
    chk("t1_c", bus.c, 0);
    chk("t1_v", bus.v, 0);
    chk("t1_busy", bus.busy, 1);
    chk("t1_in_ready", bus.in_ready, 0);
    handshake();

    run_op(16'h7FFF, 16'h0001, 1'b0, 0, lat);
    chk("t2_s", bus.s, 16'h8000);
    chk("t2_c", bus.c, 0);
    chk("t2_v", bus.v, 1);
    handshake();

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, lat);
    chk("t3_s", bus.s, 16'h0000);
    chk("t3_c", bus.c, 1);
    chk("t3_v", bus.v, 0);
`ifdef MP_ADDSUB_ZFLAG_EN
    chk("t3_z", bus.z, 1);
`endif
    handshake();

    run_op(16'h0000, 16'h0001, 1'b1, 0, lat);
    chk("t4_s", bus.s, 16'hFFFF);
    chk("t4_c", bus.c, 0);
    chk("t4_v", bus.v, 0);
`ifdef MP_ADDSUB_ZFLAG_EN
    chk("t4_z", bus.z, 0);
`endif
    handshake();

    run_op(16'h8000, 16'h0001, 1'b1, 0, lat);
    chk("t5_s", bus.s, 16'h7FFF);
    chk("t5_c", bus.c, 1);
    chk("t5_v", bus.v, 1);

    // Backpressure: result held, new operands ignored while in DONE
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'hAAAA;
      bus.b = 16'h5555;
      bus.m = 1'b0;
      @(posedge clk); #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_s", bus.s, 16'h7FFF);
      chk("bp_c", bus.c, 1);
      chk("bp_v", bus.v, 1);
    end
    bus.in_valid = 1'b0;
    handshake();
    chk("bp_idle_ready", bus.in_ready, 1);
    chk("bp_idle_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("bp_not_captured", bus.busy, 0);

    // Reset during the second RUN cycle discards the partial result
    bus.in_valid = 1'b1;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.m = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", bus.in_ready, 1);
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_s", bus.s, 0);
    chk("mr_c", bus.c, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0001, 1'b0, 0, lat);
    chk("mr_next_lat", lat, 4);
    chk("mr_next_s", bus.s, 16'h0002);
    chk("mr_next_c", bus.c, 0);
    handshake();

    // Randomized ops with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      mv = 1'($urandom_range(0, 1));
      if (i % 10 == 0) bv = av;
      exp = model(av, bv, mv);
      run_op(av, bv, mv, int'($urandom_range(0, 3)), lat);
      chk("rnd_s", bus.s, exp[15:0]);
      chk("rnd_c", bus.c, exp[16]);
      chk("rnd_v", bus.v, exp[17]);
`ifdef MP_ADDSUB_ZFLAG_EN
      chk("rnd_z", bus.z, exp[15:0] == 16'h0);
`endif
      s_hold = bus.s;
      handshake();
      chk("rnd_s_after", bus.s, s_hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
